// File: rtl/fsk_demod_pkg.sv
// FSK demodulator shared types and helpers.
// State encoding, constant clog2, and a majority vote over up to 7 bits.
package fsk_demod_pkg;

  typedef enum logic [1:0] {
    LOST    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Unused upper bits must be zero.
  function automatic logic majority(
    input logic [6:0] v,
    input int         depth
  );
    int ones;
    ones = 0;
    for (int i = 0; i < 7; i++)
      ones += int'(v[i]);
    return (2 * ones > depth);
  endfunction

endpackage

// File: rtl/fsk_period_meter.sv
// Period meter: sync of the async tone, rising-edge detect, glitch gate,
// saturating period counter. Ports: clk, rst_n, i_fsk, i_lost -> o_period,
// o_period_valid (accepted rise this clk), o_timeout (cnt saturated).
module fsk_period_meter #(
  parameter int CntW      = 6,
  parameter int MinPeriod = 5,
  parameter int MaxPeriod = 40
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_fsk,
  input  logic            i_lost,
  output logic [CntW-1:0] o_period,
  output logic            o_period_valid,
  output logic            o_timeout
);

  logic            r_s1;
  logic            r_s2;
  logic            r_prev;
  logic [CntW-1:0] r_cnt;
  logic            w_rise;
  logic            w_accept;

  assign w_rise    = r_s2 & ~r_prev;
  assign o_timeout = (r_cnt == CntW'(MaxPeriod));

  // Outside LOST a saturated count wins over a coincident rise.
  assign w_accept =
    i_lost |
    ((r_cnt >= CntW'(MinPeriod)) & ~o_timeout);

  assign o_period_valid = w_rise & w_accept;
  assign o_period       = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= i_fsk;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      if (o_period_valid)
        r_cnt <= CntW'(1);
      else if (!o_timeout)
        r_cnt <= r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/fsk_demodulator.sv
// FSK demodulator top: lock FSM, symbol vote and UART-level outputs.
// Ports: clk, rst_n, fsk_in -> RxD, carrier_detect, sym_strobe.
module fsk_demodulator
  import fsk_demod_pkg::*;
#(
  parameter int ClkFrequency = 50000000,
  parameter int MarkFreq     = 2200,
  parameter int SpaceFreq    = 1200,
  parameter int LockCount    = 4,
  parameter int VoteDepth    = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fsk_in,
  output logic RxD,
  output logic carrier_detect,
  output logic sym_strobe
);

  localparam int MarkPeriod  = ClkFrequency / MarkFreq;
  localparam int SpacePeriod = ClkFrequency / SpaceFreq;
  localparam int Threshold   = (MarkPeriod + SpacePeriod) / 2;
  localparam int MinPeriod   = MarkPeriod / 2;
  localparam int MaxPeriod   = 2 * SpacePeriod;
  localparam int CntW        = clog2(MaxPeriod + 1);

  if (MarkFreq <= SpaceFreq ||
      (VoteDepth % 2) == 0 ||
      VoteDepth < 1 || VoteDepth > 7 ||
      LockCount < 1 || LockCount > 15 ||
      MinPeriod < 2) begin : g_param_err
    $error("fsk_demodulator: illegal parameters");
  end

  state_e                r_state;
  state_e                w_state_nxt;
  logic [3:0]            r_lock_cnt;
  logic [3:0]            w_lock_nxt;
  logic                  w_classify;
  logic                  w_sym;
  logic [VoteDepth-1:0]  r_vote;
  logic                  r_rxd;
  logic                  r_cd;
  logic                  r_strobe;
  logic [CntW-1:0]       w_period;
  logic                  w_valid;
  logic                  w_timeout;

  fsk_period_meter #(
    .CntW      (CntW),
    .MinPeriod (MinPeriod),
    .MaxPeriod (MaxPeriod)
  ) u_meter (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_fsk          (fsk_in),
    .i_lost         (r_state == LOST),
    .o_period       (w_period),
    .o_period_valid (w_valid),
    .o_timeout      (w_timeout)
  );

  // Short period means the higher (mark) tone.
  assign w_sym = (w_period < CntW'(Threshold));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LOST;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_cnt;
    w_classify  = 1'b0;
    unique case (r_state)
      LOST: begin
        if (w_valid) begin
          w_state_nxt = ACQUIRE;
          w_lock_nxt  = '0;
        end
      end
      ACQUIRE: begin
        if (w_timeout) begin
          w_state_nxt = LOST;
          w_lock_nxt  = '0;
        end else if (w_valid) begin
          w_lock_nxt = r_lock_cnt + 4'd1;
          // The period that completes the count is a symbol too.
          if (w_lock_nxt == 4'(LockCount)) begin
            w_state_nxt = LOCKED;
            w_classify  = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (w_timeout) begin
          w_state_nxt = LOST;
          w_lock_nxt  = '0;
        end else if (w_valid) begin
          w_classify = 1'b1;
        end
      end
      default: begin
        w_state_nxt = LOST;
        w_lock_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_cnt <= '0;
      r_vote     <= '1;
      r_rxd      <= 1'b1;
      r_cd       <= 1'b0;
      r_strobe   <= 1'b0;
    end else begin
      r_lock_cnt <= w_lock_nxt;
      if (w_state_nxt == LOST)
        r_vote <= '1;
      else if (w_classify)
        r_vote <= VoteDepth'({r_vote, w_sym});
      r_rxd <= (r_state == LOCKED) ?
               majority(7'(r_vote), VoteDepth) : 1'b1;
      r_cd     <= (w_state_nxt == LOCKED);
      r_strobe <= w_classify;
    end
  end

  assign RxD            = r_rxd;
  assign carrier_detect = r_cd;
  assign sym_strobe     = r_strobe;

endmodule
